// File: rtl/dti_arb_pkg.sv
// Shared types for the DTI packet arbiter: FSM state encoding and pointer width helper.
package dti_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dti.sv
// Valid/ready stream interface used between the arbiter and the downstream FIFO.
interface dti #(
  parameter int DW = 16
);
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;

  modport producer (output data, output valid, input ready);
  modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/rr_pick.sv
// Round-robin winner search: first asserted request at or above ptr, wrapping N-1 -> 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          any
);

  localparam int PW1 = PW + 1;

  logic [PW:0] idx_s;

  // scan N positions from ptr; explicit compare handles non-power-of-two N
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx_s  = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = {1'b0, ptr} + PW1'(k);
      if (idx_s >= PW1'(N)) begin
        idx_s = idx_s - PW1'(N);
      end else begin
        idx_s = idx_s;
      end
      if (!any && req[idx_s[PW-1:0]]) begin
        any    = 1'b1;
        winner = idx_s[PW-1:0];
      end else begin
        any    = any;
      end
    end
  end

endmodule

// File: rtl/dti_pkt_arbiter.sv
// Packet-locking round-robin arbiter merging N requesters onto one DTI stream.
// Optional stall watchdog enabled by defining ARB_WATCHDOG_EN.
module dti_pkt_arbiter
  import dti_arb_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int DIN     = 16,
  parameter  int TIMEOUT = 256,
  localparam int PW      = ptr_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [N*DIN-1:0] req_data,
  output logic [N-1:0]     req_ready,
  dti.producer             dout,
  output logic [PW-1:0]    gnt_id,
  output logic             locked,
  output logic             wd_err
);

  arb_state_e    state_r;
  logic [PW-1:0] ptr_r;
  logic [PW-1:0] owner_r;
  logic [PW-1:0] winner_s;
  logic          any_s;
  logic [PW-1:0] sel_s;
  logic [DIN-1:0] data_s;
  logic          valid_s;
  logic          hs_s;
  logic          eot_s;
  logic          wd_fire_s;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    if (p == PW'(N - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req    (req_valid),
    .ptr    (ptr_r),
    .winner (winner_s),
    .any    (any_s)
  );

  // zero-latency mux; valid never looks at ready, reset masks both directions
  always_comb begin
    sel_s     = (state_r == LOCK) ? owner_r : winner_s;
    data_s    = req_data[int'(sel_s)*DIN +: DIN];
    valid_s   = rst ? 1'b0 : req_valid[sel_s];
    req_ready = '0;
    if (!rst) begin
      req_ready[sel_s] = dout.ready;
    end else begin
      req_ready = '0;
    end
    hs_s  = valid_s & dout.ready;
    eot_s = data_s[DIN-1];
  end

  assign dout.data  = data_s;
  assign dout.valid = valid_s;
  assign gnt_id     = sel_s;
  assign locked     = (state_r == LOCK);

`ifdef ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_r;
  logic          wd_err_r;

  assign wd_fire_s = (state_r == LOCK) && !req_valid[owner_r] && (cnt_r == CW'(TIMEOUT - 1));
  assign wd_err    = wd_err_r;

  // consecutive owner-idle cycles while locked; error flag is sticky until rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= '0;
      wd_err_r <= 1'b0;
    end else begin
      if ((state_r == LOCK) && !req_valid[owner_r] && !wd_fire_s) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= '0;
      end
      wd_err_r <= wd_err_r | wd_fire_s;
    end
  end
`else
  assign wd_fire_s = 1'b0;
  assign wd_err    = 1'b0;
`endif

  // arbitration FSM: lock on any non-final grant, rotate pointer only at packet end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      owner_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            if (hs_s && eot_s) begin
              ptr_r <= wrap_inc(winner_s);
            end else begin
              state_r <= LOCK;
              owner_r <= winner_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        LOCK: begin
          if ((hs_s && eot_s) || wd_fire_s) begin
            state_r <= IDLE;
            ptr_r   <= wrap_inc(owner_r);
          end else begin
            state_r <= LOCK;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dti_pkt_arbiter.sv
// Directed self-checking bench for dti_pkt_arbiter (N=4, DIN=16, TIMEOUT=8).
module tb_dti_pkt_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [1:0]  gnt_id;
  logic        locked;
  logic        wd_err;
  int          checks = 0;
  int          errors = 0;

  dti #(.DW(16)) dout_if ();

  dti_pkt_arbiter #(.N(4), .DIN(16), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .dout      (dout_if),
    .gnt_id    (gnt_id),
    .locked    (locked),
    .wd_err    (wd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input int i, input logic eot, input logic [14:0] pay);
    req_data[i*16 +: 16] = {eot, pay};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    req_valid       = 4'b0000;
    req_data        = 64'h0;
    dout_if.ready   = 1'b0;
    #1;
    req_valid     = 4'b0110;
    dout_if.ready = 1'b1;
    set_beat(1, 1'b1, 15'h011);
    set_beat(2, 1'b1, 15'h022);
    #1;
    chk("rst_valid", 32'(dout_if.valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_wd_err", 32'(wd_err), 32'd0);

    // alternating single-beat packets from 1 and 2
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rr_g0", 32'(gnt_id), 32'd1);
    chk("rr_d0", 32'(dout_if.data), 32'h8011);
    chk("rr_r0", 32'(req_ready), 32'h2);
    chk("rr_l0", 32'(locked), 32'd0);
    step();
    chk("rr_g1", 32'(gnt_id), 32'd2);
    chk("rr_d1", 32'(dout_if.data), 32'h8022);
    chk("rr_r1", 32'(req_ready), 32'h4);
    step();
    chk("rr_g2", 32'(gnt_id), 32'd1);
    chk("rr_l2", 32'(locked), 32'd0);
    step();
    chk("rr_g3", 32'(gnt_id), 32'd2);
    chk("rr_l3", 32'(locked), 32'd0);
    step();

    // pointer now 3: single beat from 3 moves it to 0
    req_valid = 4'b1000;
    set_beat(3, 1'b1, 15'h033);
    #1;
    chk("p3_g", 32'(gnt_id), 32'd3);
    step();

    // 3-beat packet from 0 with 3 waiting
    req_valid = 4'b1001;
    set_beat(0, 1'b0, 15'h001);
    #1;
    chk("pk_g0", 32'(gnt_id), 32'd0);
    chk("pk_r0", 32'(req_ready), 32'h1);
    chk("pk_l0", 32'(locked), 32'd0);
    step();
    set_beat(0, 1'b0, 15'h002);
    #1;
    chk("pk_g1", 32'(gnt_id), 32'd0);
    chk("pk_l1", 32'(locked), 32'd1);
    chk("pk_r1", 32'(req_ready), 32'h1);
    step();
    set_beat(0, 1'b1, 15'h003);
    #1;
    chk("pk_g2", 32'(gnt_id), 32'd0);
    chk("pk_d2", 32'(dout_if.data), 32'h8003);
    chk("pk_r2", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b1000;
    #1;
    chk("pk_g3", 32'(gnt_id), 32'd3);
    chk("pk_r3", 32'(req_ready), 32'h8);
    chk("pk_l3", 32'(locked), 32'd0);
    chk("pk_d3", 32'(dout_if.data), 32'h8033);
    step();

    // backpressure: winner 2 stalls 5 cycles, requester 1 appears meanwhile
    req_valid     = 4'b0100;
    dout_if.ready = 1'b0;
    set_beat(2, 1'b1, 15'h044);
    #1;
    chk("bp_g0", 32'(gnt_id), 32'd2);
    chk("bp_v0", 32'(dout_if.valid), 32'd1);
    chk("bp_r0", 32'(req_ready), 32'h0);
    step();
    req_valid = 4'b0110;
    set_beat(1, 1'b1, 15'h055);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_g", 32'(gnt_id), 32'd2);
      chk("bp_d", 32'(dout_if.data), 32'h8044);
      chk("bp_r", 32'(req_ready), 32'h0);
      chk("bp_l", 32'(locked), 32'd1);
      step();
    end
    dout_if.ready = 1'b1;
    #1;
    chk("bp_hs_g", 32'(gnt_id), 32'd2);
    chk("bp_hs_r", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0000;

    // reset in the middle of a packet owned by 1 (pointer is 3)
    req_valid = 4'b0010;
    set_beat(1, 1'b0, 15'h066);
    #1;
    chk("mr_g0", 32'(gnt_id), 32'd1);
    step();
    set_beat(1, 1'b0, 15'h067);
    #1;
    chk("mr_l1", 32'(locked), 32'd1);
    chk("mr_g1", 32'(gnt_id), 32'd1);
    req_valid = 4'b0011;
    set_beat(0, 1'b1, 15'h077);
    rst = 1'b1;
    #1;
    chk("mr_rv", 32'(dout_if.valid), 32'd0);
    chk("mr_rr", 32'(req_ready), 32'h0);
    chk("mr_rl", 32'(locked), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mr_g2", 32'(gnt_id), 32'd0);
    chk("mr_d2", 32'(dout_if.data), 32'h8077);
    chk("mr_r2", 32'(req_ready), 32'h1);
    chk("mr_l2", 32'(locked), 32'd0);
    step();
    req_valid = 4'b0000;

    // owner 3 stalls after one non-final beat (pointer is 1)
    req_valid = 4'b1000;
    set_beat(3, 1'b0, 15'h088);
    #1;
    chk("wd_g0", 32'(gnt_id), 32'd3);
    step();
    req_valid = 4'b0001;
    set_beat(0, 1'b1, 15'h099);
`ifdef ARB_WATCHDOG_EN
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("wd_l", 32'(locked), 32'd1);
      chk("wd_e", 32'(wd_err), 32'd0);
      chk("wd_g", 32'(gnt_id), 32'd3);
      chk("wd_v", 32'(dout_if.valid), 32'd0);
      step();
    end
    #1;
    chk("wd_fire_e", 32'(wd_err), 32'd1);
    chk("wd_fire_l", 32'(locked), 32'd0);
    chk("wd_fire_g", 32'(gnt_id), 32'd0);
    chk("wd_fire_r", 32'(req_ready), 32'h1);
    step();
    #1;
    chk("wd_sticky", 32'(wd_err), 32'd1);
`else
    for (int k = 0; k < 100; k++) begin
      #1;
      chk("nowd_l", 32'(locked), 32'd1);
      chk("nowd_e", 32'(wd_err), 32'd0);
      chk("nowd_g", 32'(gnt_id), 32'd3);
      step();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
